// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, baud-rate
// arithmetic and parity-select constants.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } uart_state_e;

    localparam bit PAR_SEL_EVEN = 1'b0;
    localparam bit PAR_SEL_ODD  = 1'b1;

    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input, with a
// selectable reset value so idle-high and idle-low lines both come up quiet.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, samples each bit at mid-bit,
// and presents the assembled word with framing, parity and overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WORD_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = PAR_SEL_EVEN
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  rx_data_in,
    output logic [WORD_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_valid,
    input  logic                  rx_ready,
    output logic                  rx_frame_err,
    output logic                  rx_parity_err,
    output logic                  rx_overrun,
    output logic                  rx_busy,
    output uart_state_e           dbg_state_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_WIDTH - 1);

    logic                  line_sync;
    logic [WORD_WIDTH:0]   shift_ext;

    uart_state_e           state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [BIT_W-1:0]      bit_q,        bit_d;
    logic [WORD_WIDTH-1:0] shift_q,      shift_d;
    logic                  par_mis_q,    par_mis_d;
    logic [WORD_WIDTH-1:0] data_q,       data_d;
    logic                  valid_q,      valid_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_q,    overrun_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (clock),
        .rst_ni (rst),
        .d_i    (rx_data_in),
        .q_o    (line_sync)
    );

    // New bits enter at the MSB and move right, so the first bit ends at the LSB.
    assign shift_ext = {line_sync, shift_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;

        // Handshake: a word transfers on any cycle where rx_data_valid and
        // rx_ready are both high; valid drops on the following cycle unless
        // a new word is loaded on that same edge.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_d     = '0;
                par_mis_d = 1'b0;
                if (!line_sync) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_ext[WORD_WIDTH:1];
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == WORD_LAST) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_mis_d = line_sync ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!line_sync) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                        if (!valid_q || rx_ready) begin
                            data_d       = shift_q;
                            valid_d      = 1'b1;
                            parity_err_d = par_mis_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // A break or stuck-low line must not look like a fresh start bit.
                cnt_d = '0;
                if (line_sync) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data_out   = data_q;
    assign rx_data_valid = valid_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_parity_err = parity_err_q;
    assign rx_overrun    = overrun_q;
    assign rx_busy       = (state_q == S_START) || (state_q == S_DATA) ||
                           (state_q == S_PARITY) || (state_q == S_STOP);
    assign dbg_state_o   = state_q;

endmodule
